// File: rtl/dc7cm_scan_if.sv
// Bus bundle for the multiplexed 7-segment scanner: data/control from the
// datapath side, segment and anode drive towards the display pins.
interface dc7cm_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic                  lzb;
  logic [6:0]            seg;
  logic                  seg_dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, load, data, dp, blank, lzb,
    input  seg, seg_dp, an, frame_done
  );

  modport slave (
    input  en, load, data, dp, blank, lzb,
    output seg, seg_dp, an, frame_done
  );
endinterface

// File: rtl/dc7cm_scan.sv
// Time-multiplexed hex display driver: scans DIGITS digits with dead time,
// leading-zero blanking and tear-free frame-synchronous data updates.
module dc7cm_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int GHOST_CYCLES   = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  dc7cm_scan_if.slave  bus
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GHOST_L  = DW'(GHOST_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]          div;
  logic [IW-1:0]          idx;
  logic [4*DIGITS-1:0]    disp_data, sh_data;
  logic [DIGITS-1:0]      disp_dp, disp_blank, sh_dp, sh_blank;
  logic                   pending;

  logic [6:0]             seg_r;
  logic                   seg_dp_r;
  logic [DIGITS-1:0]      an_r;
  logic                   frame_done_r;

  logic                   slot_end;
  logic                   wrap;
  logic [3:0]             cur_nib;
  logic [DIGITS-1:0]      lz_vec;
  logic                   upper_zero;
  logic                   dark;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h77;
      4'hB:    decode = 7'h7C;
      4'hC:    decode = 7'h39;
      4'hD:    decode = 7'h5E;
      4'hE:    decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  assign slot_end = (div == DIV_LAST);
  assign wrap     = bus.en && slot_end && (idx == IDX_LAST);
  assign cur_nib  = disp_data[{idx, 2'b00} +: 4];

  // lz_vec[i] is set when digit i and every more significant digit are zero
  always_comb begin
    upper_zero = 1'b1;
    lz_vec     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_data[4*i +: 4] == 4'd0);
      lz_vec[i]  = upper_zero;
    end
  end

  assign dark = disp_blank[idx] | (bus.lzb & (idx != '0) & lz_vec[idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div          <= '0;
      idx          <= '0;
      disp_data    <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      sh_data      <= '0;
      sh_dp        <= '0;
      sh_blank     <= '0;
      pending      <= 1'b0;
      seg_r        <= '0;
      seg_dp_r     <= 1'b0;
      an_r         <= '0;
      frame_done_r <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_data  <= bus.data;
        sh_dp    <= bus.dp;
        sh_blank <= bus.blank;
        pending  <= 1'b1;
      end

      if (bus.en) begin
        if (slot_end) begin
          div <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end

      // A load landing on the wrap cycle bypasses the shadow so it shows at once
      if (wrap) begin
        if (bus.load) begin
          disp_data  <= bus.data;
          disp_dp    <= bus.dp;
          disp_blank <= bus.blank;
        end else if (pending) begin
          disp_data  <= sh_data;
          disp_dp    <= sh_dp;
          disp_blank <= sh_blank;
        end
        pending <= 1'b0;
      end

      frame_done_r <= wrap;

      if (!bus.en || (div < GHOST_L)) begin
        an_r     <= '0;
        seg_r    <= '0;
        seg_dp_r <= 1'b0;
      end else begin
        an_r     <= DIGITS'(1) << idx;
        seg_r    <= dark ? 7'h00 : decode(cur_nib);
        seg_dp_r <= ~dark & disp_dp[idx];
      end
    end
  end

  assign bus.seg        = SEG_ACTIVE_LOW ? ~seg_r    : seg_r;
  assign bus.seg_dp     = SEG_ACTIVE_LOW ? ~seg_dp_r : seg_dp_r;
  assign bus.an         = AN_ACTIVE_LOW  ? ~an_r     : an_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_dc7cm_scan.sv
// Randomised and directed bench for dc7cm_scan, checked against a model that
// tracks elapsed enabled cycles and derives slot/digit by division.
module tb_dc7cm_scan;

  localparam int D     = 4;
  localparam int DIV   = 4;
  localparam int GHOST = 1;
  localparam int FRAME = D * DIV;

  logic clk;
  logic rst_n;
  dc7cm_scan_if #(.DIGITS(D)) bus ();

  dc7cm_scan #(
    .DIGITS(D), .REFRESH_DIV(DIV), .GHOST_CYCLES(GHOST),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int errors;

  // Active-high g..a patterns for hex 0..F
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          t;
  logic [15:0] m_data, m_sh_data;
  logic [3:0]  m_dp, m_blank, m_sh_dp, m_sh_blank;
  bit          m_pending;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic applyStimulus(input bit rstn, input bit en, input bit ld,
                               input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] b, input bit z);
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_fd;
    int         phase, digit;
    bit         dark, wrap;
    rst_n     = rstn;
    bus.en    = en;
    bus.load  = ld;
    bus.data  = d;
    bus.dp    = p;
    bus.blank = b;
    bus.lzb   = z;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = 4'hF;
    e_fd  = 1'b0;
    wrap  = 1'b0;
    if (!rstn) begin
      t = 0;
      m_data = '0; m_dp = '0; m_blank = '0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_blank = '0;
      m_pending = 1'b0;
    end else begin
      if (en) begin
        phase = t % DIV;
        digit = (t / DIV) % D;
        wrap  = (t % FRAME) == FRAME - 1;
        e_fd  = wrap;
        if (phase >= GHOST) begin
          dark = m_blank[digit] || (z && digit > 0 && (m_data >> (4 * digit)) == 16'd0);
          e_an = ~(4'b0001 << digit);
          if (!dark) begin
            e_seg = ~hex_tab[m_data[4*digit +: 4]];
            e_dp  = ~m_dp[digit];
          end
        end
        t++;
      end
      if (wrap) begin
        if (ld) begin
          m_data = d; m_dp = p; m_blank = b;
        end else if (m_pending) begin
          m_data = m_sh_data; m_dp = m_sh_dp; m_blank = m_sh_blank;
        end
        m_pending = 1'b0;
      end
      if (ld) begin
        m_sh_data = d; m_sh_dp = p; m_sh_blank = b;
        if (!wrap) m_pending = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("seg", 32'(bus.seg), 32'(e_seg));
    checkOutput("seg_dp", 32'(bus.seg_dp), 32'(e_dp));
    checkOutput("an", 32'(bus.an), 32'(e_an));
    checkOutput("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  logic [3:0] cur_dp, cur_blank;
  bit         cur_lzb;

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, en, 1'b0, 16'h0, cur_dp, cur_blank, cur_lzb);
  endtask

  // Run enabled until the next cycle is the frame-wrap cycle (bounded)
  task automatic toWrap;
    int guard;
    guard = 0;
    while ((t % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin
      idle(1, 1'b1);
      guard++;
    end
    checkOutput("wrap_reached", 32'((t % FRAME) == FRAME - 1), 32'd1);
  endtask

  initial begin
    tests = 0;
    errors = 0;
    cur_dp = '0;
    cur_blank = '0;
    cur_lzb = 1'b0;
    t = 0;

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("reset_an", 32'(bus.an), 32'h0F);
    checkOutput("reset_seg", 32'(bus.seg), 32'h7F);

    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
    idle(3 * FRAME, 1'b1);

    for (int n = 0; n < 16; n++) begin
      toWrap();
      applyStimulus(1'b1, 1'b1, 1'b1, {4{4'(n)}}, 4'h0, 4'h0, 1'b0);
      idle(FRAME, 1'b1);
    end

    cur_lzb = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0042, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
    idle(2 * FRAME, 1'b1);
    cur_lzb = 1'b0;

    toWrap();
    idle(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
    idle(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
    idle(2 * FRAME, 1'b1);

    cur_dp = 4'b0100;
    cur_blank = 4'b0001;
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h5678, cur_dp, cur_blank, 1'b0);
    idle(FRAME + 6, 1'b1);
    idle(10, 1'b0);
    idle(2 * FRAME, 1'b1);

    idle(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h9ABC, 4'hF, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
    checkOutput("midreset_an", 32'(bus.an), 32'h0F);
    checkOutput("midreset_fd", 32'(bus.frame_done), 32'h0);
    cur_dp = '0;
    cur_blank = '0;
    idle(2 * FRAME, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) != 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) == 0,
                    16'($urandom),
                    4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                    1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
